// File: rtl/wb_gpio_debounce_if.sv
// Wishbone classic slave bundle for the GPIO/debounce peripheral.
interface wb_gpio_debounce_if;
  logic        i_wb_cyc;
  logic        i_wb_stb;
  logic        i_wb_we;
  logic [31:0] i_wb_addr;
  logic [31:0] i_wb_data;
  logic        o_wb_ack;
  logic        o_wb_stall;
  logic [31:0] o_wb_data;

  modport master (
    output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
    input  o_wb_ack, o_wb_stall, o_wb_data
  );

  modport slave (
    input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
    output o_wb_ack, o_wb_stall, o_wb_data
  );
endinterface

// File: rtl/wb_gpio_debounce.sv
// Wishbone GPIO: LED write/set/clear, debounced buttons with rising-edge latch and level IRQ.
// Optional LED PWM dimming is enabled by defining WB_GPIO_PWM_EN.
module wb_gpio_debounce #(
  parameter logic [31:0] BASE_ADDRESS    = 32'h3000_0000,
  parameter int          NUM_LEDS        = 8,
  parameter int          NUM_BUTTONS     = 3,
  parameter int          DEBOUNCE_CYCLES = 1000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  wb_gpio_debounce_if.slave      wb,
  input  logic [NUM_BUTTONS-1:0] buttons,
  output logic [NUM_LEDS-1:0]    leds,
  output logic                   irq
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [31:0]            off;
  logic [2:0]             idx;
  logic                   req;
  logic                   wr;
  logic [31:0]            rd_data;
  logic                   unused_wdata;

  logic [NUM_LEDS-1:0]    led_q;
  logic [NUM_LEDS-1:0]    led_d;
  logic [NUM_BUTTONS-1:0] edge_q;
  logic [NUM_BUTTONS-1:0] edge_d;
  logic [NUM_BUTTONS-1:0] irq_en_q;
  logic [NUM_BUTTONS-1:0] w1c_mask;
  logic                   ack_q;
  logic [31:0]            rdata_q;
  logic                   irq_q;

  logic [NUM_BUTTONS-1:0] sync_p0;
  logic [NUM_BUTTONS-1:0] sync_p1;
  logic [NUM_BUTTONS-1:0] stable_q;
  logic [NUM_BUTTONS-1:0] stable_d;
  logic [NUM_BUTTONS-1:0] rise;
  logic [CNT_W-1:0]       cnt_q [NUM_BUTTONS];
  logic [CNT_W-1:0]       cnt_d [NUM_BUTTONS];

`ifdef WB_GPIO_PWM_EN
  logic [7:0]             duty_q;
  logic [7:0]             pwm_cnt_q;
  logic [NUM_LEDS-1:0]    leds_q;
`endif

  // Offset wraps to a huge value below BASE, so one compare bounds both ends of the window.
  assign off          = wb.i_wb_addr - BASE_ADDRESS;
  assign idx          = off[4:2];
  assign req          = wb.i_wb_cyc & wb.i_wb_stb & (off < 32'h20);
  assign wr           = req & wb.i_wb_we;
  assign unused_wdata = ^wb.i_wb_data;

  assign wb.o_wb_ack   = ack_q;
  assign wb.o_wb_stall = 1'b0;
  assign wb.o_wb_data  = rdata_q;
  assign irq           = irq_q;

  always_comb begin
    rd_data = '0;
    case (idx)
      3'd0: rd_data[NUM_LEDS-1:0]    = led_q;
      3'd3: rd_data[NUM_BUTTONS-1:0] = stable_q;
      3'd4: rd_data[NUM_BUTTONS-1:0] = edge_q;
      3'd5: rd_data[NUM_BUTTONS-1:0] = irq_en_q;
`ifdef WB_GPIO_PWM_EN
      3'd6: rd_data[7:0]             = duty_q;
`endif
      default: rd_data = '0;
    endcase
  end

  always_comb begin
    led_d = led_q;
    if (wr) begin
      case (idx)
        3'd0:    led_d = wb.i_wb_data[NUM_LEDS-1:0];
        3'd1:    led_d = led_q | wb.i_wb_data[NUM_LEDS-1:0];
        3'd2:    led_d = led_q & ~wb.i_wb_data[NUM_LEDS-1:0];
        default: led_d = led_q;
      endcase
    end
  end

  // Any cycle where the synchronised level matches the accepted one restarts the count.
  always_comb begin
    stable_d = stable_q;
    rise     = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      cnt_d[i] = '0;
      if (sync_p1[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          stable_d[i] = sync_p1[i];
          rise[i]     = sync_p1[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // A new rising edge overrides a same-cycle write-one-to-clear.
  assign w1c_mask = (wr && idx == 3'd4) ? wb.i_wb_data[NUM_BUTTONS-1:0] : '0;
  assign edge_d   = (edge_q & ~w1c_mask) | rise;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_q    <= 1'b0;
      rdata_q  <= '0;
      led_q    <= '0;
      edge_q   <= '0;
      irq_en_q <= '0;
      irq_q    <= 1'b0;
      sync_p0  <= '0;
      sync_p1  <= '0;
      stable_q <= '0;
      for (int i = 0; i < NUM_BUTTONS; i++) cnt_q[i] <= '0;
    end else begin
      ack_q <= req;
      if (req && !wb.i_wb_we) rdata_q <= rd_data;
      led_q <= led_d;
      if (wr && idx == 3'd5) irq_en_q <= wb.i_wb_data[NUM_BUTTONS-1:0];
      edge_q   <= edge_d;
      irq_q    <= |(edge_q & irq_en_q);
      // Two-flop synchroniser stage boundary
      sync_p0  <= buttons;
      sync_p1  <= sync_p0;
      stable_q <= stable_d;
      for (int i = 0; i < NUM_BUTTONS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

`ifdef WB_GPIO_PWM_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      duty_q    <= 8'hFF;
      pwm_cnt_q <= '0;
      leds_q    <= '0;
    end else begin
      if (wr && idx == 3'd6) duty_q <= wb.i_wb_data[7:0];
      pwm_cnt_q <= pwm_cnt_q + 8'd1;
      leds_q    <= led_q & {NUM_LEDS{pwm_cnt_q < duty_q}};
    end
  end
  assign leds = leds_q;
`else
  assign leds = led_q;
`endif

endmodule

// File: tb/tb_wb_gpio_debounce.sv
// Directed bench for wb_gpio_debounce with a cycle-level register/history model.
module tb_wb_gpio_debounce;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int NL = 8;
  localparam int NB = 3;
  localparam int DC = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [NB-1:0] buttons = '0;
  logic [NL-1:0] leds;
  logic          irq;

  wb_gpio_debounce_if wb();

  wb_gpio_debounce #(
    .BASE_ADDRESS(BASE), .NUM_LEDS(NL), .NUM_BUTTONS(NB), .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .wb(wb), .buttons(buttons), .leds(leds), .irq(irq)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: register file plus a raw pin history for the debounce rule.
  logic [NL-1:0] m_led, m_leds;
  logic [NB-1:0] m_edge, m_en, m_stable;
  logic          m_ack, m_irq;
  logic [31:0]   m_rdata;
  logic [7:0]    m_duty, m_pc;
  logic [NB-1:0] hist[$];

  function automatic logic [31:0] m_read(input logic [2:0] idx);
    logic [31:0] v;
    v = '0;
    if (idx == 3'd0) v[NL-1:0] = m_led;
    if (idx == 3'd3) v[NB-1:0] = m_stable;
    if (idx == 3'd4) v[NB-1:0] = m_edge;
    if (idx == 3'd5) v[NB-1:0] = m_en;
`ifdef WB_GPIO_PWM_EN
    if (idx == 3'd6) v[7:0] = m_duty;
`endif
    return v;
  endfunction

  task automatic m_reset();
    m_led = '0; m_leds = '0; m_edge = '0; m_en = '0; m_stable = '0;
    m_ack = 1'b0; m_irq = 1'b0; m_rdata = '0; m_duty = 8'hFF; m_pc = '0;
    hist.delete();
    for (int k = 0; k < DC + 2; k++) hist.push_back('0);
  endtask

  task automatic m_step();
    logic [31:0]   off, wd;
    logic [2:0]    idx;
    logic          req, we, all_diff;
    logic [NB-1:0] nstable, rise, w1c;
    logic [NL-1:0] nled;
    off = wb.i_wb_addr - BASE;
    req = wb.i_wb_cyc && wb.i_wb_stb && (off < 32'h20);
    we  = wb.i_wb_we;
    wd  = wb.i_wb_data;
    idx = off[4:2];
    // hist[k] is the pin level sampled k edges ago; a change is accepted once the
    // synchronised level (two edges late) has disagreed for DC consecutive edges.
    hist.push_front(buttons);
    nstable = m_stable;
    rise = '0;
    for (int i = 0; i < NB; i++) begin
      all_diff = 1'b1;
      for (int k = 2; k <= DC + 1; k++)
        if (hist[k][i] == m_stable[i]) all_diff = 1'b0;
      if (all_diff) begin
        nstable[i] = ~m_stable[i];
        rise[i]    = ~m_stable[i];
      end
    end
    void'(hist.pop_back());
    if (req && !we) m_rdata = m_read(idx);
    m_irq = |(m_edge & m_en);
    w1c = (req && we && idx == 3'd4) ? wd[NB-1:0] : '0;
    nled = m_led;
    if (req && we && idx == 3'd0) nled = wd[NL-1:0];
    if (req && we && idx == 3'd1) nled = m_led | wd[NL-1:0];
    if (req && we && idx == 3'd2) nled = m_led & ~wd[NL-1:0];
    if (req && we && idx == 3'd5) m_en = wd[NB-1:0];
`ifdef WB_GPIO_PWM_EN
    m_leds = (m_pc < m_duty) ? m_led : '0;
    m_pc   = m_pc + 8'd1;
    if (req && we && idx == 3'd6) m_duty = wd[7:0];
`else
    m_leds = nled;
`endif
    m_led    = nled;
    m_edge   = (m_edge & ~w1c) | rise;
    m_stable = nstable;
    m_ack    = req;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) m_reset();
      else m_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        chk("ack", {31'b0, wb.o_wb_ack}, {31'b0, m_ack});
        chk("rdata", wb.o_wb_data, m_rdata);
        chk("leds", {24'b0, leds}, {24'b0, m_leds});
        chk("irq", {31'b0, irq}, {31'b0, m_irq});
        chk("stall", {31'b0, wb.o_wb_stall}, 32'd0);
      end
    end
  end

  task automatic cyc_wait(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus(input logic we, input logic [31:0] addr, input logic [31:0] data,
                     input logic exp_ack, output logic [31:0] rd);
    wb.i_wb_cyc = 1'b1; wb.i_wb_stb = 1'b1; wb.i_wb_we = we;
    wb.i_wb_addr = addr; wb.i_wb_data = data;
    @(posedge clk);
    #1;
    chk($sformatf("ack_%h", addr), {31'b0, wb.o_wb_ack}, {31'b0, exp_ack});
    rd = wb.o_wb_data;
    wb.i_wb_cyc = 1'b0; wb.i_wb_stb = 1'b0; wb.i_wb_we = 1'b0;
  endtask

  task automatic wr(input logic [31:0] o, input logic [31:0] d);
    logic [31:0] v;
    bus(1'b1, BASE + o, d, 1'b1, v);
  endtask

  task automatic rdchk(input string name, input logic [31:0] o, input logic [31:0] exp);
    logic [31:0] v;
    bus(1'b0, BASE + o, 32'h0, 1'b1, v);
    chk(name, v, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] v;
    logic [31:0] seq_o [4];
    logic [31:0] seq_d [4];
    logic        seq_w [4];
    logic [31:0] seq_e [4];
    int          on_cnt;
    wb.i_wb_cyc = 1'b0; wb.i_wb_stb = 1'b0; wb.i_wb_we = 1'b0;
    wb.i_wb_addr = '0; wb.i_wb_data = '0;

    #12;
    chk("rst_ack", {31'b0, wb.o_wb_ack}, 32'd0);
    chk("rst_leds", {24'b0, leds}, 32'd0);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    chk("rst_rdata", wb.o_wb_data, 32'd0);
    #11 reset_n = 1'b1;
    @(posedge clk); #1;

    // LED write / set / clear
    wr(32'h00, 32'hA5); wr(32'h04, 32'h0F); wr(32'h08, 32'h81);
    rdchk("led_rd", 32'h00, 32'h2E);
    chk("leds_pin", {24'b0, leds}, 32'h2E);
    rdchk("set_rd0", 32'h04, 32'h0);
    rdchk("clr_rd0", 32'h08, 32'h0);

    // Short glitch is rejected
    buttons = 3'b001; cyc_wait(3); buttons = 3'b000; cyc_wait(10);
    rdchk("glitch_btn", 32'h0C, 32'h0);
    rdchk("glitch_edge", 32'h10, 32'h0);
    chk("glitch_irq", {31'b0, irq}, 32'd0);

    // Held press: accepted exactly 2+DC edges after the pin change
    wr(32'h14, 32'h2);
    rdchk("irqen_rd", 32'h14, 32'h2);
    buttons = 3'b010; cyc_wait(5);
    rdchk("btn_early", 32'h0C, 32'h0);
    rdchk("btn_press", 32'h0C, 32'h2);
    rdchk("edge_press", 32'h10, 32'h2);
    chk("irq_press", {31'b0, irq}, 32'd1);
    cyc_wait(2); buttons = 3'b000; cyc_wait(8);
    rdchk("btn_release", 32'h0C, 32'h0);
    rdchk("edge_fall_ign", 32'h10, 32'h2);

    // Clear, then W1C coinciding with a new rising edge
    wr(32'h10, 32'h2); cyc_wait(1);
    chk("irq_cleared", {31'b0, irq}, 32'd0);
    rdchk("edge_cleared", 32'h10, 32'h0);
    buttons = 3'b010; cyc_wait(5);
    wr(32'h10, 32'h2);
    rdchk("edge_set_wins", 32'h10, 32'h2);
    wr(32'h10, 32'h2);
    rdchk("edge_w1c_later", 32'h10, 32'h0);
    cyc_wait(1);
    chk("irq_w1c_later", {31'b0, irq}, 32'd0);
    buttons = 3'b000; cyc_wait(8);

    // Edge on a masked button does not raise irq
    buttons = 3'b100; cyc_wait(8);
    rdchk("edge_masked", 32'h10, 32'h4);
    chk("irq_masked", {31'b0, irq}, 32'd0);
    buttons = 3'b000; cyc_wait(8);

    // Unused window offsets and out-of-window accesses
    rdchk("rd_1c", 32'h1C, 32'h0);
`ifdef WB_GPIO_PWM_EN
    rdchk("pwm_rst", 32'h18, 32'hFF);
`else
    wr(32'h18, 32'h55);
    rdchk("rd_18", 32'h18, 32'h0);
`endif
    bus(1'b1, BASE + 32'h20, 32'hFF, 1'b0, v);
    bus(1'b0, BASE + 32'h20, 32'h0, 1'b0, v);
    bus(1'b1, BASE - 32'h4, 32'hFF, 1'b0, v);
    wb.i_wb_cyc = 1'b1; wb.i_wb_addr = BASE; wb.i_wb_we = 1'b1; wb.i_wb_data = 32'hFF;
    cyc_wait(1);
    chk("cyc_no_stb", {31'b0, wb.o_wb_ack}, 32'd0);
    wb.i_wb_cyc = 1'b0; wb.i_wb_we = 1'b0;
    rdchk("led_untouched", 32'h00, 32'h2E);

    // Back-to-back requests: ack on every cycle
    seq_o = '{32'h00, 32'h04, 32'h00, 32'h10};
    seq_d = '{32'h11, 32'h40, 32'h0, 32'h0};
    seq_w = '{1'b1, 1'b1, 1'b0, 1'b0};
    seq_e = '{32'h0, 32'h0, 32'h51, 32'h4};
    wb.i_wb_cyc = 1'b1; wb.i_wb_stb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wb.i_wb_addr = BASE + seq_o[i]; wb.i_wb_data = seq_d[i]; wb.i_wb_we = seq_w[i];
      cyc_wait(1);
      chk($sformatf("b2b_ack%0d", i), {31'b0, wb.o_wb_ack}, 32'd1);
      if (!seq_w[i]) chk($sformatf("b2b_rd%0d", i), wb.o_wb_data, seq_e[i]);
    end
    wb.i_wb_cyc = 1'b0; wb.i_wb_stb = 1'b0; wb.i_wb_we = 1'b0;

`ifdef WB_GPIO_PWM_EN
    wr(32'h00, 32'hFF); wr(32'h18, 32'h40); cyc_wait(2);
    on_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      if (leds == 8'hFF) on_cnt++;
      cyc_wait(1);
    end
    chk("pwm_40_on", on_cnt, 32'd64);
    wr(32'h18, 32'h00); cyc_wait(2);
    on_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      if (leds != 8'h00) on_cnt++;
      cyc_wait(1);
    end
    chk("pwm_0_on", on_cnt, 32'd0);
`else
    on_cnt = 0;
`endif

    // Asynchronous reset while a read is being acknowledged
    wb.i_wb_cyc = 1'b1; wb.i_wb_stb = 1'b1; wb.i_wb_addr = BASE + 32'h0C;
    @(posedge clk); #1;
    chk("ack_before_rst", {31'b0, wb.o_wb_ack}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("ack_async_drop", {31'b0, wb.o_wb_ack}, 32'd0);
    chk("leds_async_rst", {24'b0, leds}, 32'd0);
    wb.i_wb_cyc = 1'b0; wb.i_wb_stb = 1'b0;
    #3 reset_n = 1'b1;
    @(posedge clk); #1;
    rdchk("led_after_rst", 32'h00, 32'h0);
    rdchk("edge_after_rst", 32'h10, 32'h0);
    rdchk("irqen_after_rst", 32'h14, 32'h0);
    cyc_wait(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
